tdm_demux8: RTL and testbench

//  Receive end of the mux8 time-division link. Upstream serialises an 8-channel

---
 rtl/tdm_demux8_pkg.sv | 10 +
 rtl/tdm_demux8_slot_counter.sv | 24 ++
 rtl/tdm_demux8.sv | 99 +++++++++
 tb/tb_tdm_demux8.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux8_pkg.sv
// Shared sizing and state encoding for the mux8 TDM receive path.
package tdm_demux8_pkg;
    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/tdm_demux8_slot_counter.sv
// Slot counter: steps through channels, restarts at 1 on a new frame's channel 0.
module tdm_demux8_slot_counter
    import tdm_demux8_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             load1,
    input  logic             clr,
    output logic [SEL_W-1:0] cnt,
    output logic             wrap
);
    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (load1)
            cnt <= SEL_W'(1);
        else if (inc)
            cnt <= cnt + 1'b1;
    end

    // Last slot of the frame; the next increment rolls over to channel 0.
    assign wrap = &cnt;
endmodule

// File: rtl/tdm_demux8.sv
// Receive end of the mux8 link: drives the select, samples the serial bit and
// rebuilds the parallel word with a frame_valid strobe.
module tdm_demux8
    import tdm_demux8_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             d_in,
    output logic [SEL_W-1:0] chan,
    output logic [N_CH-1:0]  Y,
    output logic             frame_valid,
    output logic             sync_err,
    output logic             busy
);
    state_t            state, state_n;
    logic [SEL_W-1:0]  cnt, sh_idx;
    logic [N_CH-2:0]   shadow;
    logic              wrap, cnt_inc, cnt_load, cnt_clr;
    logic              sh_we, sh_first, y_we, se_n;

    tdm_demux8_slot_counter u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (cnt_inc),
        .load1 (cnt_load),
        .clr   (cnt_clr),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    always_comb begin
        state_n  = state;
        cnt_inc  = 1'b0;
        cnt_load = 1'b0;
        cnt_clr  = 1'b0;
        sh_we    = 1'b0;
        sh_first = 1'b0;
        y_we     = 1'b0;
        se_n     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en && sync) begin
                    sh_we    = 1'b1;
                    sh_first = 1'b1;
                    cnt_load = 1'b1;
                    state_n  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (en) begin
                    // sync always restarts the frame; it is only an error mid-frame
                    if (sync) begin
                        se_n     = (cnt != '0);
                        sh_we    = 1'b1;
                        sh_first = 1'b1;
                        cnt_load = 1'b1;
                    end else if (cnt == '0) begin
                        se_n     = 1'b1;
                        cnt_clr  = 1'b1;
                        state_n  = ST_IDLE;
                    end else if (wrap) begin
                        y_we     = 1'b1;
                        cnt_inc  = 1'b1;
                    end else begin
                        sh_we    = 1'b1;
                        cnt_inc  = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign sh_idx = sh_first ? '0 : cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            shadow      <= '0;
            Y           <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_n;
            frame_valid <= y_we;
            sync_err    <= se_n;
            if (sh_we)
                shadow[sh_idx] <= d_in;
            // channel 7 goes straight into Y, never through the shadow
            if (y_we)
                Y <= {d_in, shadow};
        end
    end

    assign busy = (state == ST_RUN);
    assign chan = busy ? cnt : '0;
endmodule

// File: tb/tb_tdm_demux8.sv
// Loop-back bench: a mux8 model selected by chan feeds d_in; a frame-level model
// predicts every output each cycle, with directed literal checks on top.
module tb_tdm_demux8;
    logic       clk = 1'b0;
    logic       reset, en, sync, d_in;
    logic [2:0] chan;
    logic [7:0] Y;
    logic       frame_valid, sync_err, busy;

    logic [7:0] word;
    logic       ovr, ovr_val;
    int         checks = 0, errors = 0;
    int         cyc = 0, start_cyc = 0, se_cnt = 0;
    int         fv_q[$];
    bit         chk_on = 1'b0;

    // model state: pos = next channel expected, -1 when not inside a frame
    int         pos;
    logic [7:0] acc, exp_y;
    logic       exp_fv, exp_se;

    always #5 clk = ~clk;

    assign d_in = ovr ? ovr_val : word[chan];

    tdm_demux8 dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .sync        (sync),
        .d_in        (d_in),
        .chan        (chan),
        .Y           (Y),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .busy        (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        exp_fv = 1'b0;
        exp_se = 1'b0;
        if (reset) begin
            pos = -1; acc = '0; exp_y = '0;
        end else if (en) begin
            if (pos < 0) begin
                if (sync) begin acc[0] = d_in; pos = 1; end
            end else if (sync) begin
                exp_se = (pos != 0);
                acc[0] = d_in;
                pos = 1;
            end else if (pos == 0) begin
                exp_se = 1'b1;
                pos = -1;
            end else begin
                acc[pos] = d_in;
                if (pos == 7) begin
                    exp_y = acc; exp_fv = 1'b1; pos = 0;
                end else begin
                    pos++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("chan", {29'd0, chan}, (pos < 0) ? 0 : pos);
            chk("y", {24'd0, Y}, {24'd0, exp_y});
            chk("frame_valid", {31'd0, frame_valid}, {31'd0, exp_fv});
            chk("sync_err", {31'd0, sync_err}, {31'd0, exp_se});
            chk("busy", {31'd0, busy}, (pos >= 0) ? 1 : 0);
            if (frame_valid) fv_q.push_back(cyc);
            if (sync_err) se_cnt++;
        end
    end

    task automatic hold(input int n);
        en = 1'b0; sync = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Sends one frame starting at channel 0; optional stall of n cycles before channel s.
    task automatic send(input logic [7:0] w, input int s, input int n);
        word = w;
        for (int i = 0; i < 8; i++) begin
            if (i == s) begin
                for (int k = 0; k < n; k++) begin
                    en = 1'b0; sync = 1'b0;
                    @(negedge clk);
                    #1 chk("stall_chan", {29'd0, chan}, s);
                end
            end
            en = 1'b1; sync = (i == 0);
            if (i == 0) start_cyc = cyc;
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        reset = 1'b1; en = 1'b0; sync = 1'b0; word = '0; ovr = 1'b0; ovr_val = 1'b0;
        @(negedge clk);
        chk_on = 1'b1;
        #1;
        chk("rst_y", {24'd0, Y}, 0);
        chk("rst_chan", {29'd0, chan}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_fv", {31'd0, frame_valid}, 0);
        reset = 1'b0;
        hold(1);

        // 1: single frame
        fv_q.delete();
        send(8'h96, -1, 0); #1;
        chk("t1_y", {24'd0, Y}, 8'h96);
        chk("t1_fv", {31'd0, frame_valid}, 1);
        lat = (fv_q.size() > 0) ? fv_q[0] - start_cyc : -1;
        chk("t1_lat", lat, 8);

        // 2: back-to-back frames
        hold(2);
        fv_q.delete(); se_cnt = 0;
        send(8'h96, -1, 0); #1;
        chk("t2_y0", {24'd0, Y}, 8'h96);
        send(8'h61, -1, 0); #1;
        chk("t2_y1", {24'd0, Y}, 8'h61);
        chk("t2_nfv", fv_q.size(), 2);
        lat = (fv_q.size() > 1) ? fv_q[1] - fv_q[0] : -1;
        chk("t2_gap", lat, 8);
        chk("t2_se", se_cnt, 0);

        // 3: three-cycle stall at cnt=4
        hold(2);
        fv_q.delete();
        send(8'h96, 4, 3); #1;
        chk("t3_y", {24'd0, Y}, 8'h96);
        lat = (fv_q.size() > 0) ? fv_q[0] - start_cyc : -1;
        chk("t3_lat", lat, 11);

        // 4: sync at cnt=5 restarts the frame
        hold(1);
        send(8'h61, -1, 0);
        hold(1);
        fv_q.delete(); se_cnt = 0;
        word = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            en = 1'b1; sync = (i == 0);
            @(negedge clk);
        end
        word = 8'h96; ovr = 1'b1; ovr_val = 1'b0; en = 1'b1; sync = 1'b1;
        @(negedge clk);
        ovr = 1'b0;
        #1;
        chk("t4_se", {31'd0, sync_err}, 1);
        chk("t4_ykeep", {24'd0, Y}, 8'h61);
        for (int i = 1; i < 8; i++) begin
            en = 1'b1; sync = 1'b0;
            @(negedge clk);
        end
        #1;
        chk("t4_y", {24'd0, Y}, 8'h96);
        chk("t4_nse", se_cnt, 1);
        chk("t4_nfv", fv_q.size(), 1);

        // 5: missing sync on channel-0 slot drops to IDLE
        se_cnt = 0;
        en = 1'b1; sync = 1'b0;
        @(negedge clk); #1;
        chk("t5_se", {31'd0, sync_err}, 1);
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_chan", {29'd0, chan}, 0);
        repeat (3) @(negedge clk);
        en = 1'b0; sync = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("t5_idle", {31'd0, busy}, 0);
        chk("t5_nse", se_cnt, 1);
        send(8'h61, -1, 0); #1;
        chk("t5_y", {24'd0, Y}, 8'h61);

        // 6: reset mid-frame at cnt=3
        hold(1);
        fv_q.delete();
        word = 8'h96;
        for (int i = 0; i < 3; i++) begin
            en = 1'b1; sync = (i == 0);
            @(negedge clk);
        end
        #1 chk("t6_cnt3", {29'd0, chan}, 3);
        reset = 1'b1; en = 1'b1; sync = 1'b0;
        @(negedge clk); #1;
        chk("t6_y", {24'd0, Y}, 0);
        chk("t6_chan", {29'd0, chan}, 0);
        chk("t6_busy", {31'd0, busy}, 0);
        chk("t6_nfv", fv_q.size(), 0);
        reset = 1'b0;
        send(8'h96, -1, 0); #1;
        chk("t6_y2", {24'd0, Y}, 8'h96);
        chk("t6_fv", {31'd0, frame_valid}, 1);

        hold(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
